uart_rx_controller: RTL and testbench
=====================================

// Module: uart_rx_controller
// PURPOSE
//   Control stage of the UART receiver. It sits alongside the majority-vote data sampler and
//   drives the sampler's enable and edge_count inputs. It consumes the sampler's voted bit,
//   deserialises start, data, optional parity and stop bits, and presents one parallel byte
//   per frame with error flags.
// PARAMETERS
//   DATA_WIDTH  8  payload bits per frame, LSB first
// PORTS
//   clk             in   1           oversampling clock (prescale edges per bit)
//   reset           in   1           asynchronous, active-low
//   serial_data     in   1           RX line, idle high; already synchronised upstream
//   prescale        in   5           edges per bit; legal values 8 or 16; sampled only in IDLE
//   parity_enable   in   1           1 = parity bit present between data and stop
//   parity_type     in   1           0 = even, 1 = odd; sampled only in IDLE
//   sampled_bit     in   1           voted bit from the sampler; valid when edge_count == prescale-1
//   sampler_enable  out  1           enable to the sampler; high in every state except IDLE
//   edge_count      out  5           edge index within the current bit, 0..prescale-1
//   parallel_data   out  DATA_WIDTH  last good byte; holds until the next good frame
//   data_valid      out  1           1-cycle pulse: parallel_data updated
//   parity_error    out  1           1-cycle pulse at end of parity bit on mismatch
//   stop_error      out  1           1-cycle pulse at end of stop bit when stop sampled 0
// BEHAVIOUR
//   Reset: state=IDLE; edge_count=0; bit_count=0; shift register=0; parallel_data=0;
//     all pulses and sampler_enable are 0. Reset mid-frame aborts the frame; no pulses.
//   Counters
//     - edge_count increments every clk outside IDLE.
//     - It wraps to 0 at prescale-1 ("bit end").
//     - bit_count (3 bits) increments at each bit end in DATA.
//   States
//     - IDLE: on serial_data==0, latch prescale/parity cfg -> START with edge_count=0.
//     - START: at bit end, sampled_bit==1 -> IDLE (glitch, no flag); else -> DATA.
//     - DATA: at bit end, shift sampled_bit in at MSB, shifting right (LSB-first line order).
//       At bit_count==DATA_WIDTH-1 -> PARITY if parity_enable, else STOP.
//     - PARITY: at bit end, compute expected = ^shift ^ parity_type.
//       Mismatch sets the internal par_bad flag and pulses parity_error. -> STOP.
//     - STOP: at bit end:
//       - sampled_bit==0: pulse stop_error.
//       - else if !par_bad: parallel_data<=shift, pulse data_valid (same cycle).
//       - Then -> IDLE; par_bad cleared.
//   Timing
//     - Pulses are registered; they assert in the cycle after the bit-end edge.
//     - First return to IDLE can re-detect start on the next clk.
//     - Back-to-back frames lose at most 1 clk.
//   Boundaries
//     - Parity and stop errors in one frame: both pulse (different cycles); no data_valid.
//     - serial_data changes outside IDLE are ignored except via sampled_bit.
//     - prescale/parity inputs changing mid-frame have no effect until next IDLE.
//     - Illegal prescale: behaviour undefined; the bench does not drive it.
// STRUCTURE
//   Shared package uart_rx_pkg: state enum {IDLE, START, DATA, PARITY, STOP} (3-bit), PRESCALE_8/16 constants.
//   Sub-module edge_bit_counter: edge_count/bit_count with enable, wrap at prescale-1, bit_end strobe.
//   Top: FSM, shift register, parity check, output registers.
// TESTING
//   1. prescale=8, no parity, send 0xA5 with good stop
//      -> one data_valid, parallel_data=0xA5, no error pulses.
//   2. prescale=16, even parity, send 0x3C with parity bit 0
//      -> data_valid, 0x3C; then parity bit 1 -> parity_error pulse, no data_valid, parallel_data stays 0x3C.
//   3. Odd parity, 0x01 with parity bit 0 -> data_valid; stop bit forced 0
//      -> stop_error pulse, no data_valid.
//   4. Low glitch of 2 clks in IDLE, prescale=8 -> START then IDLE, no pulses, no data_valid.
//   5. Two back-to-back frames 0x55, 0xFF -> two data_valid pulses, correct bytes in order.
//   6. Assert reset during DATA bit 4 -> all outputs return to reset values immediately;
//      next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Latency/backpressure: none; types and constants only.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [4:0] PRESCALE_8  = 5'd8;
  localparam logic [4:0] PRESCALE_16 = 5'd16;

  // Frame configuration captured when a start edge is seen.
  typedef struct packed {
    logic [4:0] prescale;
    logic       parity_enable;
    logic       parity_type;
  } rx_cfg_t;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge-within-bit and bit-within-frame counters; bit_end marks edge prescale-1.
// Latency: bit_end is combinational from edge_count; no backpressure, runs whenever enabled.
module edge_bit_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] prescale,
  input  logic       bit_inc,
  output logic [4:0] edge_count,
  output logic [2:0] bit_count,
  output logic       bit_end
);

  assign bit_end = enable && (edge_count == (prescale - 5'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_count <= 5'd0;
      bit_count  <= 3'd0;
    end else if (!enable) begin
      edge_count <= 5'd0;
      bit_count  <= 3'd0;
    end else begin
      edge_count <= bit_end ? 5'd0 : edge_count + 5'd1;
      if (bit_end && bit_inc) begin
        bit_count <= bit_count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive control: frames start/data/parity/stop from sampler votes into a byte plus error pulses.
// Latency: pulses one clk after the stop/parity bit end; no backpressure, a byte is lost if unread.
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_data,
  input  logic [4:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  sampled_bit,
  output logic                  sampler_enable,
  output logic [4:0]            edge_count,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  rx_state_t             state, state_nxt;
  rx_cfg_t               cfg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bad;
  logic [2:0]            bit_count;
  logic                  bit_end;
  logic                  start_det;

  assign sampler_enable = (state != IDLE);
  assign start_det      = (state == IDLE) && !serial_data;

  edge_bit_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .enable     (sampler_enable),
    .prescale   (cfg.prescale),
    .bit_inc    (state == DATA),
    .edge_count (edge_count),
    .bit_count  (bit_count),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!serial_data) state_nxt = START;
      START:   if (bit_end) state_nxt = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && (bit_count == LAST_BIT))
                 state_nxt = cfg.parity_enable ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg           <= '{PRESCALE_8, 1'b0, 1'b0};
      shift_reg     <= '0;
      par_bad       <= 1'b0;
      parallel_data <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      stop_error    <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      // Config is frozen for the whole frame so mid-frame input changes are harmless.
      if (start_det) begin
        cfg <= '{prescale, parity_enable, parity_type};
      end
      if (bit_end) begin
        case (state)
          DATA: shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          PARITY: begin
            if (sampled_bit != ((^shift_reg) ^ cfg.parity_type)) begin
              par_bad      <= 1'b1;
              parity_error <= 1'b1;
            end
          end
          STOP: begin
            if (!sampled_bit) begin
              stop_error <= 1'b1;
            end else if (!par_bad) begin
              parallel_data <= shift_reg;
              data_valid    <= 1'b1;
            end
            par_bad <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: frame table plus hand sequences, pulses scored against a queue.
// Latency/backpressure: the bench plays the sampler, presenting each bit's vote for a full bit window.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_data;
  logic [4:0] prescale;
  logic       parity_enable;
  logic       parity_type;
  logic       sampled_bit;
  logic       sampler_enable;
  logic [4:0] edge_count;
  logic [7:0] parallel_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  uart_rx_controller #(.DATA_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_data    (serial_data),
    .prescale       (prescale),
    .parity_enable  (parity_enable),
    .parity_type    (parity_type),
    .sampled_bit    (sampled_bit),
    .sampler_enable (sampler_enable),
    .edge_count     (edge_count),
    .parallel_data  (parallel_data),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .stop_error     (stop_error)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] EV_DV = 3'b100;
  localparam logic [2:0] EV_PE = 3'b010;
  localparam logic [2:0] EV_SE = 3'b001;

  typedef struct {
    logic [4:0] pre;
    logic       pen;
    logic       ptype;
    logic [7:0] dat;
    logic       pbit;
    logic       sbit;
    int         gap;
    logic       cfg_flip;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] dat;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_pd;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every pulse cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (reset === 1'b1 && (data_valid || parity_error || stop_error)) begin
      logic [2:0] obs;
      ev_t e;
      obs = {data_valid, parity_error, stop_error};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, obs}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {29'd0, obs}, {29'd0, e.kind});
        if (e.kind == EV_DV) exp_pd = e.dat;
        check("parallel_data", {24'd0, parallel_data}, {24'd0, exp_pd});
      end
    end
  end

  task automatic send_bit(input logic b, input logic [4:0] p);
    serial_data = b;
    sampled_bit = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    prescale      = v.pre;
    parity_enable = v.pen;
    parity_type   = v.ptype;
    serial_data   = 1'b0;
    sampled_bit   = 1'b0;
    @(negedge clk);
    if (v.cfg_flip) begin
      prescale      = (v.pre == 5'd8) ? 5'd16 : 5'd8;
      parity_enable = ~v.pen;
      parity_type   = ~v.ptype;
    end
    send_bit(1'b0, v.pre);
    for (int i = 0; i < 8; i++) send_bit(v.dat[i], v.pre);
    if (v.pen) send_bit(v.pbit, v.pre);
    send_bit(v.sbit, v.pre);
    serial_data = 1'b1;
    sampled_bit = 1'b1;
  endtask

  task automatic push_expected(input vec_t v);
    ev_t e;
    if (v.exp_pe) begin e.kind = EV_PE; e.dat = 8'h00; exp_q.push_back(e); end
    if (v.exp_se) begin e.kind = EV_SE; e.dat = 8'h00; exp_q.push_back(e); end
    if (v.exp_dv) begin e.kind = EV_DV; e.dat = v.dat; exp_q.push_back(e); end
  endtask

  vec_t tbl[10];
  vec_t rf;

  initial begin
    //            pre    pen   ptype dat    pbit  sbit  gap flip  dv    pe    se
    tbl[0] = '{5'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{5'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{5'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{5'd8,  1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{5'd8,  1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{5'd8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{5'd8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{5'd8,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{5'd16, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{5'd16, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0};

    exp_pd        = 8'h00;
    reset         = 1'b0;
    serial_data   = 1'b1;
    sampled_bit   = 1'b1;
    prescale      = 5'd8;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sampler_enable", {31'd0, sampler_enable}, 32'd0);
    check("rst_edge_count", {27'd0, edge_count}, 32'd0);
    check("rst_parallel_data", {24'd0, parallel_data}, 32'd0);
    check("rst_pulses", {29'd0, data_valid, parity_error, stop_error}, 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 10; k++) begin
      serial_data = 1'b1;
      sampled_bit = 1'b1;
      repeat (tbl[k].gap) @(negedge clk);
      push_expected(tbl[k]);
      send_frame(tbl[k]);
    end

    // Two-clock low glitch: START entered, sampler votes high, back to IDLE silently.
    repeat (4) @(negedge clk);
    prescale    = 5'd8;
    serial_data = 1'b0;
    sampled_bit = 1'b1;
    @(negedge clk);
    check("glitch_enable_start", {31'd0, sampler_enable}, 32'd1);
    check("glitch_edge0", {27'd0, edge_count}, 32'd0);
    @(negedge clk);
    serial_data = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_edge3", {27'd0, edge_count}, 32'd3);
    repeat (5) @(negedge clk);
    check("glitch_back_idle", {31'd0, sampler_enable}, 32'd0);
    check("glitch_edge_idle", {27'd0, edge_count}, 32'd0);
    repeat (4) @(negedge clk);

    // Reset during data bit 4 of 0x81, then a clean 0x81 frame.
    rf = '{5'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    prescale    = 5'd8;
    serial_data = 1'b0;
    sampled_bit = 1'b0;
    @(negedge clk);
    send_bit(1'b0, 5'd8);
    for (int i = 0; i < 4; i++) send_bit(rf.dat[i], 5'd8);
    serial_data = rf.dat[4];
    sampled_bit = rf.dat[4];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_pd = 8'h00;
    check("midrst_sampler_enable", {31'd0, sampler_enable}, 32'd0);
    check("midrst_edge_count", {27'd0, edge_count}, 32'd0);
    check("midrst_parallel_data", {24'd0, parallel_data}, 32'd0);
    check("midrst_pulses", {29'd0, data_valid, parity_error, stop_error}, 32'd0);
    @(negedge clk);
    serial_data = 1'b1;
    sampled_bit = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    push_expected(rf);
    send_frame(rf);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_parallel_data", {24'd0, parallel_data}, 32'h81);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
